multi_port_queue: RTL and testbench
===================================

MULTI_PORT_QUEUE -- requirements
Module: multi_port_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: entry count; power of two, >= 4.
REQ-003 SHALL have parameter ENQ_W, default 2: enqueue lanes per cycle, 1..4.
REQ-004 SHALL have parameter DEQ_W, default 2: dequeue lanes per cycle, 1..4.
REQ-005 SHALL have parameter INIT, default 0: 0 = plain FIFO; 1 = prefilled free-list.
REQ-006 SHALL have parameter VALUES, default 64: INIT=1 value space; VALUES >= DEPTH; values fit WIDTH.
REQ-007 SHALL have ports, one per line:
  clk  in  1  clock; one clock domain; all state updates on rising edge
  reset  in  1  synchronous reset, active-high
  flush  in  1  pipeline flush
  flush_inuse  in  VALUES  INIT=1 only: bit v set = value v in use at flush
  stall  in  1  blocks all dequeues this cycle
  enq_valid  in  ENQ_W  per-lane enqueue request; packed from lane 0
  enq_data  in  ENQ_W*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
  enq_ready  out  1  room for ENQ_W entries
  deq_valid  out  DEQ_W  lane i holds a valid entry
  deq_data  out  DEQ_W*WIDTH  lane i = i-th oldest entry
  deq_take  in  DEQ_W  per-lane consume; packed from lane 0
  count  out  clog2(DEPTH)+1  current occupancy
  empty  out  1  count == 0
  full  out  1  count == DEPTH

Function
REQ-008 SHALL be a circular buffer with head, tail and count registers; pointers wrap DEPTH-1 -> 0.
REQ-009 SHALL drive deq_data lane i from storage[(head+i) mod DEPTH], first-word fall-through, zero when lane invalid.
REQ-010 SHALL assert deq_valid[i] iff count > i and stall == 0.
REQ-011 SHALL assert enq_ready iff DEPTH - count >= ENQ_W, evaluated on start-of-cycle count (no credit from same-cycle dequeue).
REQ-012 SHALL accept all set enq_valid lanes when enq_ready, writing lane i at (tail+i) mod DEPTH; tail advances by popcount(enq_valid).
REQ-013 SHALL ignore all enq_valid lanes when enq_ready == 0 (all-or-nothing, no partial accept).
REQ-014 SHALL consume popcount(deq_take & deq_valid) entries; head advances by that amount; deq_take on invalid lanes is ignored.
REQ-015 SHALL update count = count + accepted - consumed in the same edge; simultaneous enqueue and dequeue net correctly.
REQ-016 SHALL not bypass: data enqueued in cycle N is first visible on deq_data in cycle N+1.
REQ-017 SHALL treat non-packed enq_valid/deq_take (hole below a set bit) as illegal; bench asserts never occurs.
REQ-018 SHALL, on flush with INIT=0, empty the queue: head=tail=count=0; same-cycle enq/deq discarded.
REQ-019 SHALL, on flush with INIT=1, refill with the free values (flush_inuse bit clear) in ascending order from slot 0, head=0, count=min(free, DEPTH), tail=count mod DEPTH.
REQ-020 SHALL give reset priority over flush, flush priority over enqueue/dequeue.

Reset
REQ-021 SHALL, on reset with INIT=0, set head=tail=count=0, storage cleared; outputs: enq_ready=1, deq_valid=0, deq_data=0, empty=1, full=0.
REQ-022 SHALL, on reset with INIT=1, set storage[i]=DEPTH+i (requires VALUES >= 2*DEPTH), head=0, tail=0, count=DEPTH; full=1, empty=0, enq_ready=0.
REQ-023 SHALL abandon any in-flight enqueue/dequeue when reset is asserted mid-operation.

Structure
REQ-024 SHALL place queue lane-count limits and the pointer-width helper in the shared processor package.
REQ-025 SHALL use one sub-module, free_value_compactor: flush_inuse -> ordered list of up to DEPTH free values plus count.

Verification
REQ-026 INIT=0, DEPTH=8, ENQ_W=2: enqueue 4 pairs 1..8 -> full=1, enq_ready=0, count=8; pair 9,10 rejected.
REQ-027 INIT=0: enqueue A,B at cycle 0 -> deq_valid=00 at cycle 0, deq_data lanes A,B with deq_valid=11 at cycle 1.
REQ-028 INIT=0, count=7, DEPTH=8: enq 2 + take 2 same cycle -> enq rejected (7+2>8), count=5.
REQ-029 INIT=0: 12 enqueues/dequeues across wrap -> FIFO order preserved, head/tail wrap 7->0.
REQ-030 INIT=1, DEPTH=32, VALUES=64: flush_inuse = bits 0..31 set -> count=32, deq lanes read 32,33.
REQ-031 Any mode: stall=1 with deq_take=11 -> deq_valid=0, count unchanged; flush with reset -> reset values.

Source files
------------

// File: rtl/multi_port_queue_pkg.sv
// Shared definitions for the multi-lane queue: lane-count limits and pointer sizing.
package multi_port_queue_pkg;

    // Widest enqueue / dequeue port the queue supports
    localparam int unsigned MaxEnqW = 4;
    localparam int unsigned MaxDeqW = 4;

    // Bits needed to index a storage array of the given depth
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/multi_port_queue_free_value_compactor.sv
// Turns an in-use bitmap into the ascending list of free values, capped at DEPTH entries.
module free_value_compactor import multi_port_queue_pkg::*; #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned VALUES = 64
) (
    input  logic [VALUES-1:0]          inuse_i,
    output logic [DEPTH*WIDTH-1:0]     free_vals_o,
    output logic [ptr_width(DEPTH):0]  free_cnt_o
);

    localparam int unsigned CntW = ptr_width(DEPTH) + 1;

    int unsigned idx;

    // Scan values low to high, packing each free one into the next output slot
    always_comb begin
        idx         = 0;
        free_vals_o = '0;
        for (int unsigned v = 0; v < VALUES; v++) begin
            if (!inuse_i[v] && idx < DEPTH) begin
                free_vals_o[idx*WIDTH +: WIDTH] = WIDTH'(v);
                idx = idx + 1;
            end
        end
        free_cnt_o = CntW'(idx);
    end

endmodule

// File: rtl/multi_port_queue.sv
// Circular queue with several enqueue and dequeue lanes per cycle; optionally acts as a
// free-list that is prefilled on reset and rebuilt from an in-use bitmap on flush.
module multi_port_queue import multi_port_queue_pkg::*; #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ENQ_W  = 2,
    parameter int unsigned DEQ_W  = 2,
    parameter int unsigned INIT   = 0,
    parameter int unsigned VALUES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [VALUES-1:0]        flush_inuse,
    input  logic                     stall,
    input  logic [ENQ_W-1:0]         enq_valid,
    input  logic [ENQ_W*WIDTH-1:0]   enq_data,
    output logic                     enq_ready,
    output logic [DEQ_W-1:0]         deq_valid,
    output logic [DEQ_W*WIDTH-1:0]   deq_data,
    input  logic [DEQ_W-1:0]         deq_take,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (ENQ_W < 1 || ENQ_W > MaxEnqW || DEQ_W < 1 || DEQ_W > MaxDeqW || DEPTH < 4 ||
        (DEPTH & (DEPTH - 1)) != 0 || VALUES < DEPTH) begin : g_param_check
        $error("multi_port_queue: illegal parameter combination");
    end

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [PtrW-1:0]        head_q, head_d;
    logic [PtrW-1:0]        tail_q, tail_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [CntW-1:0]        n_enq, n_deq;
    logic [DEPTH*WIDTH-1:0] free_vals;
    logic [CntW-1:0]        free_cnt;

    free_value_compactor #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .VALUES (VALUES)
    ) u_compactor (
        .inuse_i     (flush_inuse),
        .free_vals_o (free_vals),
        .free_cnt_o  (free_cnt)
    );

    // Status and fall-through read lanes, all from start-of-cycle state
    always_comb begin
        enq_ready = (count_q <= CntW'(DEPTH - ENQ_W));
        deq_valid = '0;
        deq_data  = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            deq_valid[i] = !stall && (count_q > CntW'(i));
            if (deq_valid[i]) begin
                deq_data[i*WIDTH +: WIDTH] = mem_q[head_q + PtrW'(i)];
            end
        end
        count = count_q;
        empty = (count_q == '0);
        full  = (count_q == CntW'(DEPTH));
    end

    // Next state: all-or-nothing enqueue, lane-wise dequeue, flush overrides both
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        n_enq   = '0;
        n_deq   = '0;
        if (enq_ready) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (enq_valid[i]) begin
                    mem_d[tail_q + PtrW'(i)] = enq_data[i*WIDTH +: WIDTH];
                    n_enq = n_enq + CntW'(1);
                end
            end
        end
        for (int i = 0; i < DEQ_W; i++) begin
            if (deq_take[i] && deq_valid[i]) begin
                n_deq = n_deq + CntW'(1);
            end
        end
        head_d  = head_q + n_deq[PtrW-1:0];
        tail_d  = tail_q + n_enq[PtrW-1:0];
        count_d = count_q + n_enq - n_deq;
        if (flush) begin
            head_d = '0;
            if (INIT == 0) begin
                tail_d  = '0;
                count_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_d[i] = free_vals[i*WIDTH +: WIDTH];
                end
                count_d = free_cnt;
                tail_d  = free_cnt[PtrW-1:0];
            end
        end
    end

    // State registers; free-list mode resets to the upper half of the value space
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            if (INIT == 0) begin
                count_q <= '0;
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else begin
                count_q <= CntW'(DEPTH);
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(DEPTH + i);
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_multi_port_queue.sv
// Scoreboard bench: plain FIFO instance under directed + random traffic, and a free-list
// instance checked through reset, stall and flush rebuilds.
module tb_multi_port_queue;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 8;
    localparam int unsigned FD = 32;
    localparam int unsigned V  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Plain FIFO instance
    logic           rst, flush, stall;
    logic [V-1:0]   main_inuse;
    logic [1:0]     ev, take, dv;
    logic [2*W-1:0] ed, dd;
    logic           rdy, emp, ful;
    logic [3:0]     cnt;

    multi_port_queue #(
        .WIDTH (W), .DEPTH (D), .ENQ_W (2), .DEQ_W (2), .INIT (0), .VALUES (V)
    ) dut (
        .clk (clk), .reset (rst), .flush (flush), .flush_inuse (main_inuse),
        .stall (stall), .enq_valid (ev), .enq_data (ed), .enq_ready (rdy),
        .deq_valid (dv), .deq_data (dd), .deq_take (take), .count (cnt),
        .empty (emp), .full (ful)
    );

    // Free-list instance
    logic           fl_rst, fl_flush, fl_stall;
    logic [V-1:0]   fl_inuse;
    logic [1:0]     fl_ev, fl_take, fl_dv;
    logic [2*W-1:0] fl_ed, fl_dd;
    logic           fl_rdy, fl_emp, fl_ful;
    logic [5:0]     fl_cnt;

    multi_port_queue #(
        .WIDTH (W), .DEPTH (FD), .ENQ_W (2), .DEQ_W (2), .INIT (1), .VALUES (V)
    ) dut_fl (
        .clk (clk), .reset (fl_rst), .flush (fl_flush), .flush_inuse (fl_inuse),
        .stall (fl_stall), .enq_valid (fl_ev), .enq_data (fl_ed), .enq_ready (fl_rdy),
        .deq_valid (fl_dv), .deq_data (fl_dd), .deq_take (fl_take), .count (fl_cnt),
        .empty (fl_emp), .full (fl_ful)
    );

    // Reference model: sb holds queued entries oldest first, model_cnt the occupancy
    int unsigned sb[$];
    int          model_cnt = 0;
    bit          mon_en    = 1'b0;

    // Monitor: compare every output mid-cycle, pop entries the DUT hands out
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("count", 64'(cnt), 64'(model_cnt));
            chk("enq_ready", 64'(rdy), 64'(model_cnt <= int'(D) - 2));
            chk("empty", 64'(emp), 64'(model_cnt == 0));
            chk("full", 64'(ful), 64'(model_cnt == int'(D)));
            for (int i = 0; i < 2; i++) begin
                if (!stall && model_cnt > i) begin
                    chk("deq_valid", 64'(dv[i]), 64'(1));
                    if (sb.size() > i) chk("deq_data", 64'(dd[i*W +: W]), 64'(sb[i]));
                    else fail("scoreboard_underflow");
                end else begin
                    chk("deq_valid_low", 64'(dv[i]), 64'(0));
                    chk("deq_data_zero", 64'(dd[i*W +: W]), 64'(0));
                end
            end
            if (!flush) begin
                for (int i = 0; i < 2; i++) begin
                    if (dv[i] && take[i] && sb.size() > 0) void'(sb.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; accepted enqueues go onto the scoreboard immediately
    task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] t, input logic s, input logic f);
        int acc;
        int cons;
        int nxt;
        ev = v; ed = {d1, d0}; take = t; stall = s; flush = f;
        if (v == 2'b10 || t == 2'b10) fail("packed_lanes");
        acc  = 0;
        cons = 0;
        if (!f) begin
            if (model_cnt <= int'(D) - 2) begin
                if (v[0]) begin sb.push_back(d0); acc++; end
                if (v[1]) begin sb.push_back(d1); acc++; end
            end
            if (!s) begin
                for (int i = 0; i < 2; i++) if (t[i] && model_cnt > i) cons++;
            end
        end
        nxt = f ? 0 : model_cnt + acc - cons;
        @(posedge clk); #1;
        if (f) sb.delete();
        model_cnt = nxt;
        ev = '0; take = '0; stall = 1'b0; flush = 1'b0;
    endtask

    // Reset, optionally colliding with enqueue, dequeue and flush
    task automatic do_reset(input logic busy);
        rst = 1'b1;
        if (busy) begin
            ev = 2'b11; ed = {$urandom, $urandom}; take = 2'b11; flush = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0; ev = '0; take = '0; flush = 1'b0;
        sb.delete();
        model_cnt = 0;
    endtask

    function automatic logic [1:0] rnd_lanes(input int unsigned hi_pct);
        int unsigned r;
        r = $urandom_range(99);
        if (r < hi_pct) return 2'b11;
        if (r < hi_pct + (100 - hi_pct) / 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic free_list(input logic [V-1:0] iu, output int unsigned q[$]);
        q = {};
        for (int v = 0; v < int'(V); v++) begin
            if (!iu[v] && q.size() < FD) q.push_back(v);
        end
    endtask

    // Expect the free-list instance to hold exactly q, then drain and compare it
    task automatic fl_expect_list(input int unsigned vals[$]);
        int unsigned q[$];
        q = vals;
        @(negedge clk);
        chk("fl_count", 64'(fl_cnt), 64'(q.size()));
        chk("fl_full", 64'(fl_ful), 64'(q.size() == FD));
        chk("fl_empty", 64'(fl_emp), 64'(q.size() == 0));
        while (q.size() > 0) begin
            chk("fl_valid0", 64'(fl_dv[0]), 64'(1));
            chk("fl_lane0", 64'(fl_dd[W-1:0]), 64'(q[0]));
            chk("fl_valid1", 64'(fl_dv[1]), 64'(q.size() > 1));
            chk("fl_lane1", 64'(fl_dd[2*W-1:W]), (q.size() > 1) ? 64'(q[1]) : 64'(0));
            fl_take = 2'b11;
            void'(q.pop_front());
            if (q.size() > 0) void'(q.pop_front());
            @(posedge clk); #1;
            fl_take = '0;
            @(negedge clk);
            chk("fl_drain_count", 64'(fl_cnt), 64'(q.size()));
        end
        chk("fl_drained_empty", 64'(fl_emp), 64'(1));
    endtask

    task automatic fl_flush_to(input logic [V-1:0] iu);
        int unsigned q[$];
        fl_inuse = iu; fl_flush = 1'b1; fl_take = 2'b11;
        @(posedge clk); #1;
        fl_flush = 1'b0; fl_take = '0;
        free_list(iu, q);
        fl_expect_list(q);
    endtask

    task automatic fl_check_reset_values(input string tag);
        chk({tag, "_count"}, 64'(fl_cnt), 64'(FD));
        chk({tag, "_full"}, 64'(fl_ful), 64'(1));
        chk({tag, "_empty"}, 64'(fl_emp), 64'(0));
        chk({tag, "_ready"}, 64'(fl_rdy), 64'(0));
        chk({tag, "_valid"}, 64'(fl_dv), 64'(2'b11));
        chk({tag, "_lane0"}, 64'(fl_dd[W-1:0]), 64'(FD));
        chk({tag, "_lane1"}, 64'(fl_dd[2*W-1:W]), 64'(FD + 1));
    endtask

    task automatic fl_phase();
        fl_rst = 1'b1;
        @(posedge clk); #1;
        fl_rst = 1'b0;
        @(negedge clk);
        fl_check_reset_values("fl_reset");
        fl_take = 2'b11;
        @(posedge clk); #1;
        fl_take = '0;
        @(negedge clk);
        chk("fl_take_count", 64'(fl_cnt), 64'(FD - 2));
        chk("fl_take_ready", 64'(fl_rdy), 64'(1));
        chk("fl_take_lane0", 64'(fl_dd[W-1:0]), 64'(FD + 2));
        chk("fl_take_lane1", 64'(fl_dd[2*W-1:W]), 64'(FD + 3));
        // Stall hides every lane and blocks the take
        fl_stall = 1'b1; fl_take = 2'b11;
        #1;
        chk("fl_stall_valid", 64'(fl_dv), 64'(0));
        chk("fl_stall_data", 64'(fl_dd), 64'(0));
        @(posedge clk); #1;
        fl_stall = 1'b0; fl_take = '0;
        @(negedge clk);
        chk("fl_stall_count", 64'(fl_cnt), 64'(FD - 2));
        fl_flush_to({32'h0, 32'hFFFF_FFFF});
        fl_flush_to({$urandom, $urandom});
        fl_flush_to({$urandom, $urandom} | {$urandom, $urandom});
        fl_flush_to({V{1'b1}});
        fl_flush_to('0);
        // Reset wins over a same-cycle flush
        fl_rst = 1'b1; fl_flush = 1'b1; fl_inuse = {$urandom, $urandom}; fl_take = 2'b11;
        @(posedge clk); #1;
        fl_rst = 1'b0; fl_flush = 1'b0; fl_take = '0;
        @(negedge clk);
        fl_check_reset_values("fl_reset_flush");
    endtask

    initial begin
        int unsigned hi;
        logic [1:0]  v;
        logic [1:0]  t;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; ev = '0; ed = '0; take = '0; main_inuse = '0;
        fl_rst = 1'b1; fl_flush = 1'b0; fl_stall = 1'b0; fl_ev = '0; fl_ed = '0;
        fl_take = '0; fl_inuse = '0;
        repeat (2) @(posedge clk);
        #1;
        fl_phase();

        do_reset(1'b0);
        mon_en = 1'b1;
        // No bypass: lanes appear the cycle after the enqueue
        step(2'b11, 32'hA, 32'hB, 2'b00, 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
        // Fill to full; the fifth pair must be rejected
        for (int k = 0; k < 4; k++) step(2'b11, 32'(2 * k + 1), 32'(2 * k + 2), 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'd9, 32'd10, 2'b00, 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0);
        repeat (4) step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
        // Count 7: a pair is refused even while two entries leave
        for (int k = 0; k < 3; k++) step(2'b11, 32'h50 + 32'(2 * k), 32'h51 + 32'(2 * k), 2'b00, 1'b0, 1'b0);
        step(2'b01, 32'h56, 32'h0, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h70, 32'h71, 2'b11, 1'b0, 1'b0);
        repeat (3) step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
        // Single-lane traffic walks the pointers around the ring
        for (int k = 0; k < 12; k++) step(2'b01, 32'h100 + 32'(k), 32'h0, 2'b01, 1'b0, 1'b0);
        step(2'b11, 32'h200, 32'h201, 2'b00, 1'b0, 1'b1);

        for (int c = 0; c < 800; c++) begin
            hi = (((c / 64) % 2) == 0) ? 70 : 20;
            v  = rnd_lanes(hi);
            t  = rnd_lanes(100 - hi);
            if (c == 400) do_reset(1'b1);
            else step(v, $urandom, $urandom, t, $urandom_range(7) == 0, $urandom_range(49) == 0);
        end
        mon_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
